// File: rtl/gon.sv
// rtl/gon.sv - global output network: round-robin PE result collector with scan-programmed row/column tags
// Optional feature macro: GON_ZERO_SKIP_EN (zero-valued words are acked but not emitted).
module gon #(
  parameter int BITWIDTH   = 16,
  parameter int TAG_LENGTH = 4,
  parameter int X_BUS_SIZE = 4,
  parameter int Y_BUS_SIZE = 4,
  localparam int NUM_PE        = X_BUS_SIZE * Y_BUS_SIZE,
  localparam int PACKET_LENGTH = 2 * TAG_LENGTH + BITWIDTH,
  localparam int CHAIN_LEN     = Y_BUS_SIZE + NUM_PE
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       program_en,
  input  logic [TAG_LENGTH-1:0]      scan_tag_in,
  output logic [TAG_LENGTH-1:0]      scan_tag_out,
  input  logic [NUM_PE-1:0]          pe_valid,
  input  logic [BITWIDTH*NUM_PE-1:0] pe_value,
  output logic [NUM_PE-1:0]          pe_ack,
  output logic                       gon_valid,
  input  logic                       gon_ready,
  output logic [PACKET_LENGTH-1:0]   data_packet
);

  localparam int PTR_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                               state_q, state_d;
  logic [PTR_W-1:0]                     ptr_q, ptr_d;
  logic [PACKET_LENGTH-1:0]             data_packet_q, data_packet_d;
  logic [CHAIN_LEN-1:0][TAG_LENGTH-1:0] chain_q, chain_d;

  logic [NUM_PE-1:0]     grant_oh;
  logic                  found;
  logic                  load_en;
  logic                  emit;
  logic [TAG_LENGTH-1:0] sel_row;
  logic [TAG_LENGTH-1:0] sel_col;
  logic [BITWIDTH-1:0]   sel_val;
  logic [PTR_W-1:0]      ptr_next;

  assign gon_valid    = (state_q == FULL);
  assign data_packet  = data_packet_q;
  assign scan_tag_out = chain_q[CHAIN_LEN-1];
  assign load_en      = rstb && !program_en && (!gon_valid || gon_ready) && (|pe_valid);
  assign pe_ack       = load_en ? grant_oh : '0;

  // Round robin: first valid at or above ptr, otherwise the lowest valid index (wrap).
  always_comb begin
    found    = 1'b0;
    grant_oh = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (!found && pe_valid[i] && (PTR_W'(i) >= ptr_q)) begin
        grant_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PE; i++) begin
      if (!found && pe_valid[i]) begin
        grant_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Pushed word n lands in e[CHAIN_LEN-1-n]: row tags first, then one column tag per PE.
  always_comb begin
    sel_row  = '0;
    sel_col  = '0;
    sel_val  = '0;
    ptr_next = ptr_q;
    for (int i = 0; i < NUM_PE; i++) begin
      if (grant_oh[i]) begin
        sel_row  = chain_q[CHAIN_LEN-1-(i / X_BUS_SIZE)];
        sel_col  = chain_q[CHAIN_LEN-1-Y_BUS_SIZE-i];
        sel_val  = pe_value[BITWIDTH*i +: BITWIDTH];
        ptr_next = (i == NUM_PE - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

`ifdef GON_ZERO_SKIP_EN
  assign emit = load_en && (sel_val != '0);
`else
  assign emit = load_en;
`endif

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    data_packet_d = data_packet_q;
    chain_d       = chain_q;
    if (program_en) begin
      chain_d[0] = scan_tag_in;
      for (int k = 1; k < CHAIN_LEN; k++) begin
        chain_d[k] = chain_q[k-1];
      end
    end
    if (load_en) begin
      ptr_d = ptr_next;
    end
    if (emit) begin
      state_d       = FULL;
      data_packet_d = {sel_row, sel_col, sel_val};
    end else if ((state_q == FULL) && gon_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q       <= EMPTY;
      ptr_q         <= '0;
      data_packet_q <= '0;
      chain_q       <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      data_packet_q <= data_packet_d;
      chain_q       <= chain_d;
    end
  end

endmodule

// File: tb/tb_gon.sv
// tb/tb_gon.sv - scoreboard bench for gon: queue-based reference model plus negedge packet monitor
module tb_gon;
  localparam int BW  = 16;
  localparam int TL  = 4;
  localparam int X   = 4;
  localparam int Y   = 4;
  localparam int NPE = X * Y;
  localparam int PL  = 2 * TL + BW;
  localparam int CL  = Y + NPE;
`ifdef GON_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstb;
  logic              program_en;
  logic [TL-1:0]     scan_tag_in;
  logic [TL-1:0]     scan_tag_out;
  logic [NPE-1:0]    pe_valid;
  logic [BW*NPE-1:0] pe_value;
  logic [NPE-1:0]    pe_ack;
  logic              gon_valid;
  logic              gon_ready;
  logic [PL-1:0]     data_packet;

  gon dut (
    .clk(clk), .rstb(rstb), .program_en(program_en),
    .scan_tag_in(scan_tag_in), .scan_tag_out(scan_tag_out),
    .pe_valid(pe_valid), .pe_value(pe_value), .pe_ack(pe_ack),
    .gon_valid(gon_valid), .gon_ready(gon_ready), .data_packet(data_packet)
  );

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  int            m_ptr;
  bit            m_full;
  int            m_chain[CL];
  bit            pend_v[NPE];
  logic [BW-1:0] pend_d[NPE];
  logic [PL-1:0] exp_q[$];
  logic [NPE-1:0] last_ack;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_pend();
    bit a = 1'b0;
    for (int i = 0; i < NPE; i++) a |= pend_v[i];
    return a;
  endfunction

  // One clock cycle: drive PE lines, predict and check the grant, advance the model.
  task automatic cycle();
    logic [NPE-1:0] exp_ack;
    logic [PL-1:0]  pkt;
    bit             load;
    int             g;
    for (int i = 0; i < NPE; i++) begin
      pe_valid[i]            = pend_v[i];
      pe_value[BW*i +: BW]   = pend_d[i];
    end
    #1;
    chk("gon_valid", gon_valid, m_full);
    chk("scan_tag_out", scan_tag_out, m_chain[CL-1]);
    load    = rstb && !program_en && (!m_full || gon_ready) && any_pend();
    g       = -1;
    exp_ack = '0;
    if (load) begin
      for (int k = 0; k < NPE; k++)
        if (g < 0 && pend_v[(m_ptr + k) % NPE]) g = (m_ptr + k) % NPE;
      exp_ack[g] = 1'b1;
    end
    last_ack = pe_ack;
    chk("pe_ack", pe_ack, exp_ack);
    if (!rstb) begin
      m_ptr  = 0;
      m_full = 1'b0;
      foreach (m_chain[k]) m_chain[k] = 0;
      exp_q.delete();
    end else begin
      if (load) begin
        pkt = {TL'(m_chain[CL-1-g/X]), TL'(m_chain[CL-1-Y-g]), pend_d[g]};
        if (!ZS || pend_d[g] != '0) begin
          exp_q.push_back(pkt);
          m_full = 1'b1;
        end else if (m_full && gon_ready) begin
          m_full = 1'b0;
        end
        m_ptr     = (g + 1) % NPE;
        pend_v[g] = 1'b0;
      end else if (m_full && gon_ready) begin
        m_full = 1'b0;
      end
      if (program_en) begin
        for (int k = CL - 1; k > 0; k--) m_chain[k] = m_chain[k-1];
        m_chain[0] = int'(scan_tag_in);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    gon_ready  = 1'b1;
    program_en = 1'b0;
    rstb       = 1'b1;
    for (int n = 0; n < 100 && (m_full || any_pend()); n++) cycle();
    chk("drain_valid", gon_valid, 1'b0);
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    cycle();
    rstb = 1'b1;
  endtask

  // Monitor: whenever a packet is presented it must match the oldest expected one.
  always @(negedge clk) begin
    if (rstb === 1'b1 && gon_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_packet: got %0h expected none at %0t", data_packet, $time);
      end else begin
        chk("data_packet", data_packet, exp_q[0]);
        if (gon_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  initial begin
    int prog_words[CL] = '{6,5,4,3, 5,4,3,2, 4,3,2,1, 3,2,1,0, 0,0,0,0};
    int p0;
    int cnt;
    logic [BW-1:0] v2;

    m_ptr  = 0;
    m_full = 1'b0;
    foreach (m_chain[k]) m_chain[k] = 0;
    for (int i = 0; i < NPE; i++) begin
      pend_v[i] = 1'b0;
      pend_d[i] = '0;
    end
    rstb        = 1'b0;
    program_en  = 1'b0;
    gon_ready   = 1'b0;
    scan_tag_in = '0;
    pe_valid    = '1;
    pe_value    = '1;
    #1;
    chk("reset_ack", pe_ack, '0);
    @(posedge clk);
    #1;
    chk("reset_valid", gon_valid, 1'b0);
    chk("reset_packet", data_packet, '0);
    chk("reset_scan_out", scan_tag_out, '0);
    rstb = 1'b1;

    // Scenario 1: program tags, single PE5 transfer
    for (int n = 0; n < CL; n++) begin
      program_en  = 1'b1;
      scan_tag_in = TL'(prog_words[n]);
      cycle();
    end
    program_en = 1'b0;
    chk("s1_scan_out", scan_tag_out, 4'd6);
    pend_v[5]  = 1'b1;
    pend_d[5]  = 16'h1234;
    gon_ready  = 1'b1;
    cycle();
    chk("s1_ack", last_ack, 16'h0020);
    chk("s1_valid", gon_valid, 1'b1);
    chk("s1_packet", data_packet, 24'h53_1234);
    drain();

    // Scenario 2: all PEs valid, back-to-back
    do_reset();
    for (int i = 0; i < NPE; i++) begin
      pend_v[i] = 1'b1;
      pend_d[i] = BW'($urandom);
    end
    p0  = pops;
    cnt = 0;
    gon_ready = 1'b1;
    for (int n = 0; n < 40 && any_pend(); n++) begin
      cycle();
      if (n < NPE) chk("s2_ack_order", last_ack, 16'h1 << n);
      cnt++;
    end
    chk("s2_cycles", cnt, NPE);
    cycle();
    chk("s2_packets", pops - p0, NPE);
    chk("s2_empty", gon_valid, 1'b0);

    // Scenario 3: stall with PE2 held, PE7 waiting
    v2 = BW'($urandom);
    pend_v[2] = 1'b1; pend_d[2] = v2;
    pend_v[7] = 1'b1; pend_d[7] = BW'($urandom);
    gon_ready = 1'b0;
    cycle();
    chk("s3_first_ack", last_ack, 16'h0004);
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("s3_stall_ack", last_ack, '0);
      chk("s3_hold", data_packet, {8'h00, v2});
    end
    gon_ready = 1'b1;
    cycle();
    chk("s3_consume_load_ack", last_ack, 16'h0080);
    drain();

    // Scenario 4: PE0 and PE3 continuously valid
    gon_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NPE; i += 3) begin
        if ((i == 0 || i == 3) && !pend_v[i]) begin
          pend_v[i] = 1'b1;
          pend_d[i] = BW'($urandom);
        end
      end
      cycle();
      chk("s4_alternate", last_ack, (n % 2 == 0) ? 16'h0001 : 16'h0008);
    end

    // Scenario 5a: programming blocks grants, held packet still consumed
    for (int i = 0; i < NPE; i++) begin
      pend_v[i] = 1'b1;
      pend_d[i] = BW'($urandom);
    end
    program_en = 1'b1;
    for (int n = 0; n < 5; n++) begin
      scan_tag_in = TL'($urandom);
      cycle();
      chk("s5_program_ack", last_ack, '0);
    end
    program_en = 1'b0;
    for (int i = 0; i < NPE; i++) pend_v[i] = 1'b0;
    drain();

    // Scenario 5b: reset with a held packet
    pend_v[9] = 1'b1; pend_d[9] = 16'hbeef;
    gon_ready = 1'b0;
    cycle();
    chk("s5_loaded", gon_valid, 1'b1);
    rstb = 1'b0;
    cycle();
    rstb = 1'b1;
    chk("s5_reset_valid", gon_valid, 1'b0);
    chk("s5_reset_packet", data_packet, '0);
    for (int i = 0; i < NPE; i++) pend_v[i] = 1'b1;
    gon_ready = 1'b1;
    cycle();
    chk("s5_restart_ack", last_ack, 16'h0001);
    drain();

    // Scenario 6: zero-valued word
    do_reset();
    pend_v[1] = 1'b1; pend_d[1] = 16'h0000;
    pend_v[2] = 1'b1; pend_d[2] = 16'h0007;
    p0 = pops;
    drain();
    chk("s6_packets", pops - p0, ZS ? 1 : 2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NPE; i++) begin
        if (!pend_v[i] && $urandom_range(3) == 0) begin
          pend_v[i] = 1'b1;
          pend_d[i] = ($urandom_range(7) == 0) ? '0 : BW'($urandom);
        end
      end
      gon_ready   = ($urandom_range(3) != 0);
      program_en  = ($urandom_range(19) == 0);
      scan_tag_in = TL'($urandom);
      rstb        = ($urandom_range(199) != 0);
      cycle();
    end
    drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gon.md
# gon

Global output network (GON) for the PE array: the return path of the global input network. Collects result words from the X_BUS_SIZE × Y_BUS_SIZE PEs with a round-robin arbiter. Tags each word with the PE's scan-programmed row and column IDs and emits one `{row_tag, col_tag, data}` packet per cycle toward the output buffer over a valid/ready handshake. The tag scan chain has the same length and load order as the GIN chain, so both networks are programmed from the same memory image.

## Interface
- `BITWIDTH`, 16: PE data word width.
- `TAG_LENGTH`, 4: row/column tag width.
- `X_BUS_SIZE`, 4: PEs per row.
- `Y_BUS_SIZE`, 4: number of rows.
- Derived (not overridable): `NUM_PE = X_BUS_SIZE*Y_BUS_SIZE`; `PACKET_LENGTH = 2*TAG_LENGTH+BITWIDTH`; `CHAIN_LEN = Y_BUS_SIZE+NUM_PE`.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rstb` in 1: reset, synchronous, active-low.
- `program` in 1: scan-chain shift enable; blocks all PE grants while high.
- `scan_tag_in` in TAG_LENGTH: scan-chain serial input word.
- `scan_tag_out` in→out TAG_LENGTH: output; last chain entry, for daisy-chaining.
- `pe_valid` in NUM_PE: bit i high means PE i holds a result.
- `pe_value` in BITWIDTH*NUM_PE: PE i data at `[BITWIDTH*i +: BITWIDTH]`, i = r*X_BUS_SIZE + c.
- `pe_ack` out NUM_PE: one-hot grant; PE i transfers on an edge where `pe_valid[i] && pe_ack[i]`.
- `gon_valid` out 1: `data_packet` holds a packet.
- `gon_ready` in 1: downstream accepts the packet.
- `data_packet` out PACKET_LENGTH: `{row_tag, col_tag, data}`.

## Operation
- **Scan chain.** Holds CHAIN_LEN entries, e[0..CHAIN_LEN-1].
  - Each edge with `program`=1: e[k] <= e[k-1]; e[0] <= `scan_tag_in`.
  - `scan_tag_out` = e[CHAIN_LEN-1].
  - After exactly CHAIN_LEN shifts, pushed word n sits in e[CHAIN_LEN-1-n].
  - Words 0..Y-1 are the row tags for rows 0..Y-1. Word Y+i is the column tag for PE i.
- **Load condition.** `load_en = !program && (!gon_valid || gon_ready) && |pe_valid`.
- **Arbiter.** A round-robin pointer `ptr` (0..NUM_PE-1) is held in a register.
  - Grant g = the first index with `pe_valid` set, searching ptr, ptr+1, … with wrap modulo NUM_PE.
  - `pe_ack` = one-hot(g) when `load_en`, else 0. It is combinational from `pe_valid`, `program`, `gon_valid`, `gon_ready` and state.
- **On a load edge:**
  - `data_packet` <= {rowtag(g / X), coltag(g), value(g)}.
  - `gon_valid` <= 1.
  - `ptr` <= (g+1) mod NUM_PE.
- **Consume without load.** `gon_valid && gon_ready && !load_en` → `gon_valid` <= 0. `data_packet` keeps its last value.
- **States.**
  - EMPTY (`gon_valid`=0) → FULL on load.
  - FULL → FULL on consume+load, or while stalled.
  - FULL → EMPTY on consume without load.
- **Stall.** While FULL and `gon_ready`=0, `data_packet` is stable and `pe_ack`=0.
- **Programming with a pending packet.** `program` does not drop a held packet; it can still be consumed.
- **Tag changes.** Tags are sampled at the load edge. Reprogramming never alters a packet already held.

## Timing
- **Reset values** (edge with `rstb`=0):
  - `gon_valid`=0, `data_packet`=0, `ptr`=0.
  - All chain entries 0, so `scan_tag_out`=0.
  - `pe_ack` forced to 0 while `rstb`=0.
- **Reset mid-stream.** A held packet is discarded and never appears on the bus.
- **Latency.** PE transfer at edge t → `gon_valid`/`data_packet` visible after edge t, i.e. one cycle.
- **Throughput.** One packet per cycle sustained when `gon_ready`=1.
- **Simultaneous events.**
  - Consume and load on the same edge is legal and leaves `gon_valid` at 1.
  - `program` and `gon_ready` in the same cycle → consume only, no load.
- **Wrap-around.** With ptr=NUM_PE-1, a grant to PE NUM_PE-1 sets ptr=0.
- **Scan timing.** The scan chain shifts one word per `program` edge. `scan_tag_out` updates after the edge.

## Configuration
- **`GON_ZERO_SKIP_EN` defined:**
  - A granted word whose data is 0 is acked and `ptr` advances.
  - No packet is produced: `gon_valid` <= 0 if the current packet was consumed, otherwise it holds.
  - Load condition is unchanged.
- **Undefined:** zero-valued words are emitted as normal packets.

## Test plan
Programming sequence used by scenarios 1–3: push 6,5,4,3, 5,4,3,2, 4,3,2,1, 3,2,1,0, 0,0,0,0 with `program`=1 for 20 edges. Resulting tags: row0..3 = 6,5,4,3; PE5 column tag = 3.

1. Program as above; PE5 valid with 16'h1234, `gon_ready`=1 → `pe_ack`=16'h0020 that cycle; next cycle `gon_valid`=1, `data_packet`={4'd5, 4'd3, 16'h1234}. After the 20 shifts, `scan_tag_out`=6.
2. All 16 PEs valid, held until acked, `gon_ready`=1 → acks for PE0..PE15 on 16 consecutive cycles; 16 back-to-back packets; then `gon_valid`=0.
3. PE2 and PE7 valid, `gon_ready`=0 → packet for PE2 held stable and `pe_ack`=0 for 5 cycles. Then `gon_ready`=1 → PE2 consumed and PE7 acked on the same edge.
4. PE0 and PE3 continuously valid, `gon_ready`=1 → grant order 0,3,0,3,…; `ptr` wraps correctly.
5. Two cases:
   - `program`=1 with PEs valid → `pe_ack`=0 throughout.
   - `rstb`=0 for one edge while `gon_valid`=1 → `gon_valid`=0, `data_packet`=0; next grant starts from PE0.
6. PE1 = 0, PE2 = 7, both valid:
   - With `GON_ZERO_SKIP_EN`: both acked, a single packet with data 7.
   - Without it: two packets, data 0 then 7.
